// File: rtl/data_pack_pkg.sv
// Shared types and helpers for the narrow-to-wide data packer.
package data_pack_pkg;

  // Widest packed word the lane-placement helper can handle.
  localparam int unsigned MAX_PACK_W = 256;

  typedef logic [MAX_PACK_W-1:0] pack_word_t;

  typedef enum logic {
    LANE_MSB_FIRST = 1'b0,
    LANE_LSB_FIRST = 1'b1
  } lane_order_e;

  // Lane counter width: enough for 0..ratio-1, never narrower than one bit.
  function automatic int unsigned lane_width(input int unsigned ratio);
    return (ratio <= 32'd1) ? 32'd1 : 32'($clog2(ratio));
  endfunction

  // Valid-lane count width: enough for 0..ratio.
  function automatic int unsigned count_width(input int unsigned ratio);
    return 32'($clog2(ratio + 32'd1));
  endfunction

  // Map the integer MSB_FIRST parameter onto the lane order enum.
  function automatic lane_order_e order_from_param(input int unsigned msb_first);
    return (msb_first != 32'd0) ? LANE_MSB_FIRST : LANE_LSB_FIRST;
  endfunction

  // Write one beat into its lane slot of a word, leaving other lanes untouched.
  function automatic pack_word_t place_beat(input pack_word_t  word,
                                            input pack_word_t  beat,
                                            input int unsigned lane,
                                            input lane_order_e order,
                                            input int unsigned in_w,
                                            input int unsigned out_w);
    int unsigned pos;
    pack_word_t  mask;
    pos  = (order == LANE_MSB_FIRST) ? (out_w - (lane + 32'd1) * in_w) : (lane * in_w);
    mask = (pack_word_t'(1) << in_w) - pack_word_t'(1);
    return (word & ~(mask << pos)) | ((beat & mask) << pos);
  endfunction

endpackage

// File: rtl/data_pack_gen_pack_out_reg.sv
// Single-entry valid/ready output register for packed words.
module pack_out_reg
  import data_pack_pkg::*;
#(
  parameter int unsigned OUT_W = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [OUT_W-1:0] load_word,
  input  logic [CNT_W-1:0] load_cnt,
  output logic [OUT_W-1:0] dout,
  output logic [CNT_W-1:0] dout_cnt,
  output logic             dout_en,
  input  logic             dout_rdy,
  output logic             ready
);

  // Register can take a new word when empty or being drained this cycle.
  assign ready = !dout_en || dout_rdy;

  // Load a completed word, otherwise drop valid once the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      dout_cnt <= '0;
      dout_en  <= 1'b0;
    end else if (load) begin
      dout     <= load_word;
      dout_cnt <= load_cnt;
      dout_en  <= 1'b1;
    end else if (dout_en && dout_rdy) begin
      dout_en  <= 1'b0;
    end
  end

endmodule

// File: rtl/data_pack_gen.sv
// Narrow-to-wide packer: gathers RATIO beats of IN_W bits into one word,
// with lane order selection, partial flush on din_last and valid/ready on both sides.
module data_pack_gen
  import data_pack_pkg::*;
#(
  parameter int unsigned IN_W      = 2,
  parameter int unsigned RATIO     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [IN_W-1:0]                     din,
  input  logic                                din_en,
  input  logic                                din_last,
  output logic                                din_rdy,
  output logic [IN_W*RATIO-1:0]               dout,
  output logic                                dout_en,
  output logic [count_width(RATIO)-1:0]       dout_cnt,
  input  logic                                dout_rdy
);

  localparam int unsigned OUT_W  = IN_W * RATIO;
  localparam int unsigned LANE_W = lane_width(RATIO);
  localparam int unsigned CNT_W  = count_width(RATIO);
  localparam lane_order_e ORDER  = order_from_param(MSB_FIRST);

  logic [LANE_W-1:0] lane;
  logic [OUT_W-1:0]  acc;
  logic [OUT_W-1:0]  word_next;
  logic [CNT_W-1:0]  word_cnt;
  logic              out_ready;
  logic              accept;
  logic              complete;

  // Input handshake; held open during reset so upstream never sees a stall there.
  assign din_rdy  = rst || out_ready;
  assign accept   = din_en && din_rdy;
  assign complete = accept && (din_last || (lane == LANE_W'(RATIO - 32'd1)));

  // Accumulator with the current beat merged into its lane slot.
  assign word_next = OUT_W'(place_beat(pack_word_t'(acc), pack_word_t'(din),
                                       32'(lane), ORDER, IN_W, OUT_W));
  assign word_cnt  = CNT_W'(lane) + CNT_W'(1);

  // Lane counter and partial-word accumulator; cleared on every completed word.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane <= '0;
      acc  <= '0;
    end else if (complete) begin
      lane <= '0;
      acc  <= '0;
    end else if (accept) begin
      lane <= lane + LANE_W'(1);
      acc  <= word_next;
    end
  end

  pack_out_reg #(
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (complete),
    .load_word (word_next),
    .load_cnt  (word_cnt),
    .dout      (dout),
    .dout_cnt  (dout_cnt),
    .dout_en   (dout_en),
    .dout_rdy  (dout_rdy),
    .ready     (out_ready)
  );

endmodule

// File: tb/tb_data_pack_gen.sv
// Bench for data_pack_gen: three configurations (2b x4 MSB-first, 2b x4 LSB-first,
// 4b x1) with a per-instance expected-word queue checked on every output handshake.
module tb_data_pack_gen;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] c;
  } exp_t;

  typedef struct {
    int              inst;
    int              n;
    logic [3:0][3:0] beats;
    bit              last;
    logic [7:0]      d;
    logic [2:0]      c;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din_v      [3];
  logic       din_en_v   [3];
  logic       last_v     [3];
  logic       dout_rdy_v [3];
  logic       din_rdy_v  [3];
  logic       dout_en_v  [3];
  logic [7:0] dout_v     [3];
  logic [2:0] cnt_v      [3];
  logic [3:0] dout_c;
  logic       cnt_c;

  always #5 clk = ~clk;

  data_pack_gen #(.IN_W(2), .RATIO(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .din(din_v[0][1:0]), .din_en(din_en_v[0]), .din_last(last_v[0]),
    .din_rdy(din_rdy_v[0]), .dout(dout_v[0]), .dout_en(dout_en_v[0]), .dout_cnt(cnt_v[0]),
    .dout_rdy(dout_rdy_v[0]));

  data_pack_gen #(.IN_W(2), .RATIO(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .din(din_v[1][1:0]), .din_en(din_en_v[1]), .din_last(last_v[1]),
    .din_rdy(din_rdy_v[1]), .dout(dout_v[1]), .dout_en(dout_en_v[1]), .dout_cnt(cnt_v[1]),
    .dout_rdy(dout_rdy_v[1]));

  data_pack_gen #(.IN_W(4), .RATIO(1), .MSB_FIRST(1)) u_r1 (
    .clk(clk), .rst(rst), .din(din_v[2]), .din_en(din_en_v[2]), .din_last(last_v[2]),
    .din_rdy(din_rdy_v[2]), .dout(dout_c), .dout_en(dout_en_v[2]), .dout_cnt(cnt_c),
    .dout_rdy(dout_rdy_v[2]));

  assign dout_v[2] = {4'h0, dout_c};
  assign cnt_v[2]  = {2'b00, cnt_c};

  int   n_cmp  = 0;
  int   n_err  = 0;
  int   stalls = 0;
  int   words  [3];
  exp_t q0[$], q1[$], q2[$];
  logic [7:0] mword [3];
  int         mcnt  [3];
  vec_t       vecs[$];

  function automatic int inw(input int i);   return (i == 2) ? 4 : 2; endfunction
  function automatic int ratio(input int i); return (i == 2) ? 1 : 4; endfunction
  function automatic bit msb(input int i);   return i != 1;            endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic bit pop(input int i, output exp_t e);
    e = '0;
    case (i)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); return 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); return 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); return 1'b1; end
    endcase
    return 1'b0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      mword[i] = '0;
      mcnt[i]  = 0;
    end
  endfunction

  // Shift-register reference: MSB-first shifts left, LSB-first ORs into the next slot.
  function automatic void model_beat(input int i, input logic [3:0] b, input bit last);
    logic [7:0] bb;
    exp_t       e;
    bb = 8'(b) & 8'((1 << inw(i)) - 1);
    if (msb(i)) mword[i] = (mword[i] << inw(i)) | bb;
    else        mword[i] = mword[i] | (bb << (inw(i) * mcnt[i]));
    mcnt[i]++;
    if (mcnt[i] == ratio(i) || last) begin
      e.d = msb(i) ? (mword[i] << (inw(i) * (ratio(i) - mcnt[i]))) : mword[i];
      e.c = 3'(mcnt[i]);
      push(i, e);
      mword[i] = '0;
      mcnt[i]  = 0;
    end
  endfunction

  function automatic void add_vec(input int inst, input int n, input logic [3:0] b0,
                                  input logic [3:0] b1, input logic [3:0] b2,
                                  input logic [3:0] b3, input bit last,
                                  input logic [7:0] d, input logic [2:0] c);
    vec_t v;
    v.inst  = inst;
    v.n     = n;
    v.beats = {b3, b2, b1, b0};
    v.last  = last;
    v.d     = d;
    v.c     = c;
    vecs.push_back(v);
  endfunction

  // Present one beat and hold it until accepted; called at posedge+#1, returns at posedge+#1.
  task automatic send(input int i, input logic [3:0] b, input bit last, input bit model);
    int t;
    t = 0;
    din_v[i]    = b;
    din_en_v[i] = 1'b1;
    last_v[i]   = last;
    @(negedge clk);
    if (!din_rdy_v[i]) stalls++;
    while (!din_rdy_v[i] && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) chk("send_timeout", 32'(t), 32'd0);
    else if (model) model_beat(i, b, last);
    @(posedge clk);
    #1;
    din_en_v[i] = 1'b0;
    last_v[i]   = 1'b0;
  endtask

  // Scoreboard: every output handshake must match the oldest expected word.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (dout_en_v[i] && dout_rdy_v[i]) begin
          words[i]++;
          ok = pop(i, e);
          if (!ok) begin
            chk("sb_unexpected_word", {24'h0, dout_v[i]}, 32'hFFFF_FFFF);
          end else begin
            chk("sb_dout", {24'h0, dout_v[i]}, {24'h0, e.d});
            chk("sb_cnt",  {29'h0, cnt_v[i]},  {29'h0, e.c});
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         w0;
    logic [7:0] held;
    int         t;

    // Table: inst, n beats, b0..b3, last on final beat, expected dout, expected cnt.
    add_vec(0, 4, 4'h1, 4'h2, 4'h3, 4'h0, 1'b0, 8'h6C, 3'd4);
    add_vec(0, 3, 4'h1, 4'h2, 4'h3, 4'h0, 1'b1, 8'h6C, 3'd3);
    add_vec(0, 4, 4'h3, 4'h3, 4'h3, 4'h3, 1'b0, 8'hFF, 3'd4);
    add_vec(0, 4, 4'h3, 4'h2, 4'h1, 4'h0, 1'b1, 8'hE4, 3'd4);
    add_vec(0, 1, 4'h2, 4'h0, 4'h0, 4'h0, 1'b1, 8'h80, 3'd1);
    add_vec(0, 2, 4'h0, 4'h1, 4'h0, 4'h0, 1'b1, 8'h10, 3'd2);
    add_vec(1, 4, 4'h1, 4'h2, 4'h3, 4'h0, 1'b0, 8'h39, 3'd4);
    add_vec(1, 3, 4'h1, 4'h2, 4'h3, 4'h0, 1'b1, 8'h39, 3'd3);
    add_vec(1, 1, 4'h2, 4'h0, 4'h0, 4'h0, 1'b1, 8'h02, 3'd1);
    add_vec(1, 2, 4'h3, 4'h1, 4'h0, 4'h0, 1'b1, 8'h07, 3'd2);
    add_vec(2, 1, 4'hA, 4'h0, 4'h0, 4'h0, 1'b0, 8'h0A, 3'd1);
    add_vec(2, 1, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0, 8'h05, 3'd1);
    add_vec(2, 1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 8'h0F, 3'd1);
    add_vec(2, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00, 3'd1);

    for (int i = 0; i < 3; i++) begin
      din_v[i] = '0; din_en_v[i] = 1'b0; last_v[i] = 1'b0; dout_rdy_v[i] = 1'b1; words[i] = 0;
    end
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_dout",    {24'h0, dout_v[i]}, 32'h0);
      chk("reset_dout_en", {31'h0, dout_en_v[i]}, 32'h0);
      chk("reset_cnt",     {29'h0, cnt_v[i]}, 32'h0);
      chk("reset_din_rdy", {31'h0, din_rdy_v[i]}, 32'h1);
    end
    @(posedge clk);
    #1;

    // First word: one clock of latency, dout_en for exactly one clock
    push(0, '{d: 8'h6C, c: 3'd4});
    send(0, 4'h1, 1'b0, 1'b0);
    send(0, 4'h2, 1'b0, 1'b0);
    send(0, 4'h3, 1'b0, 1'b0);
    send(0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_dout_en", {31'h0, dout_en_v[0]}, 32'h1);
    chk("lat_dout",    {24'h0, dout_v[0]}, 32'h6C);
    chk("lat_cnt",     {29'h0, cnt_v[0]}, 32'h4);
    @(negedge clk);
    chk("pulse_dout_en", {31'h0, dout_en_v[0]}, 32'h0);
    @(posedge clk);
    #1;

    // Table-driven vectors
    foreach (vecs[v]) begin
      push(vecs[v].inst, '{d: vecs[v].d, c: vecs[v].c});
      for (int k = 0; k < vecs[v].n; k++)
        send(vecs[v].inst, vecs[v].beats[k], vecs[v].last && (k == vecs[v].n - 1), 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;

    // Gaps in din_en, with a stray din_last while idle, must not disturb packing
    push(0, '{d: 8'h6C, c: 3'd4});
    send(0, 4'h1, 1'b0, 1'b0);
    last_v[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    last_v[0] = 1'b0;
    send(0, 4'h2, 1'b0, 1'b0);
    send(0, 4'h3, 1'b0, 1'b0);
    send(0, 4'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Continuous 400-beat stream, LSB-first
    stalls = 0;
    w0 = words[1];
    for (int k = 0; k < 400; k++) send(1, 4'($urandom_range(0, 3)), 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("stream_words",  32'(words[1] - w0), 32'd100);
    chk("stream_stalls", 32'(stalls), 32'd0);

    // Random beats through the RATIO=1 instance
    for (int k = 0; k < 20; k++) send(2, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: word A held stable for 10 clocks, B stalls then follows in order
    dout_rdy_v[0] = 1'b0;
    fork
      begin
        send(0, 4'h1, 1'b0, 1'b1);
        send(0, 4'h2, 1'b0, 1'b1);
        send(0, 4'h3, 1'b0, 1'b1);
        send(0, 4'h0, 1'b0, 1'b1);
        send(0, 4'h2, 1'b0, 1'b1);
        send(0, 4'h1, 1'b0, 1'b1);
        send(0, 4'h3, 1'b0, 1'b1);
        send(0, 4'h2, 1'b0, 1'b1);
      end
      begin
        t = 0;
        @(negedge clk);
        while (!dout_en_v[0] && t < 50) begin
          t++;
          @(negedge clk);
        end
        chk("bp_dout_en", {31'h0, dout_en_v[0]}, 32'h1);
        held = dout_v[0];
        chk("bp_word_a", {24'h0, held}, 32'h6C);
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          chk("bp_hold_dout",  {24'h0, dout_v[0]}, {24'h0, held});
          chk("bp_hold_en",    {31'h0, dout_en_v[0]}, 32'h1);
          chk("bp_din_rdy",    {31'h0, din_rdy_v[0]}, 32'h0);
        end
        @(posedge clk);
        #1;
        dout_rdy_v[0] = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("bp_drained", 32'(q0.size()), 32'd0);

    // Reset after two beats discards the partial word
    send(0, 4'h1, 1'b0, 1'b0);
    send(0, 4'h2, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midrst_dout",    {24'h0, dout_v[0]}, 32'h0);
    chk("midrst_dout_en", {31'h0, dout_en_v[0]}, 32'h0);
    chk("midrst_cnt",     {29'h0, cnt_v[0]}, 32'h0);
    @(posedge clk);
    #1;
    push(0, '{d: 8'hC6, c: 3'd4});
    send(0, 4'h3, 1'b0, 1'b0);
    send(0, 4'h0, 1'b0, 1'b0);
    send(0, 4'h1, 1'b0, 1'b0);
    send(0, 4'h2, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    // Nothing left outstanding
    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    chk("q2_empty", 32'(q2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
